// File: rtl/mips_sc_core_pkg.sv
// Shared definitions for the single-cycle MIPS32 subset core:
// opcode/funct encodings, ALU operation codes and the decoded control bundle.
package mips_sc_core_pkg;

  localparam logic [31:0] HEAP_BASE_DEF = 32'h1000_0000;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] SP_INIT_DEF   = 32'h1000_0FFC;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;

  typedef enum logic [5:0] {
    ALU_ADD  = 6'd0,  ALU_SUB  = 6'd1,  ALU_AND  = 6'd2,  ALU_OR   = 6'd3,
    ALU_XOR  = 6'd4,  ALU_NOR  = 6'd5,  ALU_SLT  = 6'd6,  ALU_SLTU = 6'd7,
    ALU_SLL  = 6'd8,  ALU_SRL  = 6'd9,  ALU_SRA  = 6'd10, ALU_LUI  = 6'd11
  } alu_ctrl_e;

  typedef struct packed {
    logic      reg_dst;
    logic      reg_write;
    logic      alu_src;
    logic      zero_ext;
    logic      mem_to_reg;
    logic      mem_write;
    logic      branch;
    logic      branch_ne;
    logic      jump;
    logic      jal;
    logic      jr;
    logic      syscall;
    alu_ctrl_e alu_ctrl;
  } ctrl_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_sc_core_ctrl.sv
// Controlunit: purely combinational decode of op/funct into the control bundle.
// Anything not recognised decodes to all-zero controls, i.e. a plain PC+4.
module Controlunit
  import mips_sc_core_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl          = '0;
    ctrl.alu_ctrl = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: ctrl.alu_ctrl = ALU_ADD;
          FN_SUB, FN_SUBU: ctrl.alu_ctrl = ALU_SUB;
          FN_AND:          ctrl.alu_ctrl = ALU_AND;
          FN_OR:           ctrl.alu_ctrl = ALU_OR;
          FN_XOR:          ctrl.alu_ctrl = ALU_XOR;
          FN_NOR:          ctrl.alu_ctrl = ALU_NOR;
          FN_SLT:          ctrl.alu_ctrl = ALU_SLT;
          FN_SLTU:         ctrl.alu_ctrl = ALU_SLTU;
          FN_SLL:          ctrl.alu_ctrl = ALU_SLL;
          FN_SRL:          ctrl.alu_ctrl = ALU_SRL;
          FN_SRA:          ctrl.alu_ctrl = ALU_SRA;
          FN_JR: begin
            ctrl.reg_write = 1'b0;
            ctrl.jr        = 1'b1;
          end
          FN_SYSCALL: begin
            ctrl.reg_write = 1'b0;
            ctrl.syscall   = 1'b1;
          end
          default: ctrl.reg_write = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      OP_SLTI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_ctrl  = ALU_SLT;
      end
      OP_SLTIU: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_ctrl  = ALU_SLTU;
      end
      OP_ANDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.zero_ext  = 1'b1;
        ctrl.alu_ctrl  = ALU_AND;
      end
      OP_ORI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.zero_ext  = 1'b1;
        ctrl.alu_ctrl  = ALU_OR;
      end
      OP_XORI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.zero_ext  = 1'b1;
        ctrl.alu_ctrl  = ALU_XOR;
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.zero_ext  = 1'b1;
        ctrl.alu_ctrl  = ALU_LUI;
      end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl.branch   = 1'b1;
        ctrl.alu_ctrl = ALU_SUB;
      end
      OP_BNE: begin
        ctrl.branch    = 1'b1;
        ctrl.branch_ne = 1'b1;
        ctrl.alu_ctrl  = ALU_SUB;
      end
      OP_J:   ctrl.jump = 1'b1;
      OP_JAL: begin
        ctrl.jump      = 1'b1;
        ctrl.jal       = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      default: ctrl.reg_write = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_sc_core_datapath.sv
// Datapath: PC register, 32x32 register file, ALU and next-PC / writeback muxes.
// Register and PC writes land at the clock edge, so same-cycle reads see old values.
module Datapath
  import mips_sc_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] SP_INIT  = SP_INIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [25:0] instr,
  input  ctrl_t       ctrl,
  input  logic [31:0] read_data,
  output logic [31:0] pc,
  output logic [31:0] alu_result,
  output logic [31:0] write_data
);

  logic [31:0] regs [32];
  logic [4:0]  rs, rt, rd, shamt, wr_addr;
  logic [31:0] rs_val, rt_val, imm_ext, alu_b, pc_plus4, pc_next, wr_data;
  logic        zero, take_branch;

  assign rs         = instr[25:21];
  assign rt         = instr[20:16];
  assign rd         = instr[15:11];
  assign shamt      = instr[10:6];
  assign rs_val     = regs[rs];
  assign rt_val     = regs[rt];
  assign write_data = rt_val;
  assign imm_ext    = ctrl.zero_ext ? {16'h0000, instr[15:0]} : sext16(instr[15:0]);
  assign alu_b      = ctrl.alu_src ? imm_ext : rt_val;

  always_comb begin
    case (ctrl.alu_ctrl)
      ALU_ADD:  alu_result = rs_val + alu_b;
      ALU_SUB:  alu_result = rs_val - alu_b;
      ALU_AND:  alu_result = rs_val & alu_b;
      ALU_OR:   alu_result = rs_val | alu_b;
      ALU_XOR:  alu_result = rs_val ^ alu_b;
      ALU_NOR:  alu_result = ~(rs_val | alu_b);
      ALU_SLT:  alu_result = {31'd0, ($signed(rs_val) < $signed(alu_b))};
      ALU_SLTU: alu_result = {31'd0, (rs_val < alu_b)};
      ALU_SLL:  alu_result = alu_b << shamt;
      ALU_SRL:  alu_result = alu_b >> shamt;
      ALU_SRA:  alu_result = $unsigned($signed(alu_b) >>> shamt);
      ALU_LUI:  alu_result = {alu_b[15:0], 16'h0000};
      default:  alu_result = 32'h0000_0000;
    endcase
  end

  assign zero        = (alu_result == 32'h0000_0000);
  assign take_branch = ctrl.branch & (ctrl.branch_ne ? ~zero : zero);
  assign pc_plus4    = pc + 32'd4;

  always_comb begin
    if (ctrl.jr) begin
      pc_next = rs_val;
    end else if (ctrl.jump) begin
      pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (take_branch) begin
      pc_next = pc_plus4 + {imm_ext[29:0], 2'b00};
    end else begin
      pc_next = pc_plus4;
    end
  end

  assign wr_addr = ctrl.jal ? 5'd31 : (ctrl.reg_dst ? rd : rt);
  assign wr_data = ctrl.jal ? pc_plus4 : (ctrl.mem_to_reg ? read_data : alu_result);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= RESET_PC;
    else        pc <= pc_next;
  end

  // r0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= (i == 29) ? SP_INIT : 32'h0000_0000;
    end else if (ctrl.reg_write && (wr_addr != 5'd0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/mips_sc_core_ram.sv
// ram: word-indexed RAM with synchronous write and combinational read; no reset.
module ram #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] Dmem [WORDS];

  always_ff @(posedge clk) begin
    if (we) Dmem[addr] <= wdata;
  end

  assign rdata = Dmem[addr];

endmodule

// File: rtl/mips_sc_core.sv
// mips_sc_core: single-cycle MIPS32 subset core; wires decoder, datapath and
// the split data RAM / heap RAM with the address decode and load-data mux.
module mips_sc_core
  import mips_sc_core_pkg::*;
#(
  parameter logic [31:0] HEAP_BASE  = HEAP_BASE_DEF,
  parameter int          DMEM_WORDS = 1024,
  parameter int          HEAP_WORDS = 1024,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] SP_INIT    = SP_INIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc,
  input  logic [31:0] instr,
  output logic        syscall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we
);

  localparam int DAW = $clog2(DMEM_WORDS);
  localparam int HAW = $clog2(HEAP_WORDS);

  ctrl_t       ctrl;
  logic        heap_sel, unused_bits;
  logic [31:0] heap_off, dmem_rdata, heap_rdata, read_data;

  Controlunit u_ctrl (
    .op   (instr[31:26]),
    .funct(instr[5:0]),
    .ctrl (ctrl)
  );

  Datapath #(.RESET_PC(RESET_PC), .SP_INIT(SP_INIT)) u_datapath (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr[25:0]),
    .ctrl      (ctrl),
    .read_data (read_data),
    .pc        (pc),
    .alu_result(mem_addr),
    .write_data(mem_wdata)
  );

  assign heap_sel    = (mem_addr >= HEAP_BASE);
  assign heap_off    = mem_addr - HEAP_BASE;
  assign mem_we      = ctrl.mem_write;
  assign syscall     = ctrl.syscall;
  assign unused_bits = ^{heap_off[31:HAW+2], heap_off[1:0]};

  // Store enables also qualified by reset so a store caught by reset never commits.
  ram #(.WORDS(DMEM_WORDS)) dmem (
    .clk  (clk),
    .we   (mem_we & reset & ~heap_sel),
    .addr (mem_addr[DAW+1:2]),
    .wdata(mem_wdata),
    .rdata(dmem_rdata)
  );

  ram #(.WORDS(HEAP_WORDS)) heap_ram (
    .clk  (clk),
    .we   (mem_we & reset & heap_sel),
    .addr (heap_off[HAW+1:2]),
    .wdata(mem_wdata),
    .rdata(heap_rdata)
  );

  assign read_data = heap_sel ? heap_rdata : dmem_rdata;

endmodule

// File: tb/tb_mips_sc_core.sv
// Self-checking bench for mips_sc_core: the bench acts as instruction ROM,
// drives a vector table through a scoreboard and checks PC, registers and memories.
module tb_mips_sc_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc, instr, mem_addr, mem_wdata;
  logic        syscall, mem_we;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] exp_pc;
    bit          chk;
    logic [4:0]  rn;
    logic [31:0] val;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wd;
    bit          sys;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  mips_sc_core dut (
    .clk      (clk),
    .reset    (reset),
    .pc       (pc),
    .instr    (instr),
    .syscall  (syscall),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we)
  );

  function automatic logic [31:0] ei(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] er(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [4:0] sh, logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] ej(logic [5:0] op, logic [25:0] t);
    return {op, t};
  endfunction

  function automatic vec_t mk(logic [31:0] ins, logic [31:0] exp_pc, bit chk, logic [4:0] rn,
                              logic [31:0] val, bit we = 1'b0, logic [31:0] addr = 32'h0,
                              logic [31:0] wd = 32'h0, bit sys = 1'b0);
    vec_t v;
    v.ins = ins; v.exp_pc = exp_pc; v.chk = chk; v.rn = rn; v.val = val;
    v.we = we; v.addr = addr; v.wd = wd; v.sys = sys;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Drive one instruction after the falling edge; compare its effects after the rising edge.
  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    instr = v.ins;
    sb.push_back(v);
    #1;
    check($sformatf("v%0d_we", idx), {31'd0, mem_we}, {31'd0, v.we});
    check($sformatf("v%0d_syscall", idx), {31'd0, syscall}, {31'd0, v.sys});
    if (v.we) begin
      check($sformatf("v%0d_addr", idx), mem_addr, v.addr);
      check($sformatf("v%0d_wdata", idx), mem_wdata, v.wd);
    end
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check($sformatf("v%0d_sb_empty", idx), 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check($sformatf("v%0d_pc", idx), pc, e.exp_pc);
      if (e.chk) check($sformatf("v%0d_r%0d", idx, e.rn), dut.u_datapath.regs[e.rn], e.val);
    end
  endtask

  initial begin
    vecs.push_back(mk(ei(6'h08, 5'd0, 5'd8, 16'd5),       32'h04, 1'b1, 5'd8,  32'd5));
    vecs.push_back(mk(ei(6'h08, 5'd0, 5'd9, 16'hFFFF),    32'h08, 1'b1, 5'd9,  32'hFFFF_FFFF));
    vecs.push_back(mk(er(5'd0, 5'd9, 5'd10, 5'd0, 6'h2B), 32'h0C, 1'b1, 5'd10, 32'd1));
    vecs.push_back(mk(er(5'd0, 5'd9, 5'd11, 5'd0, 6'h2A), 32'h10, 1'b1, 5'd11, 32'd0));
    vecs.push_back(mk(ei(6'h0F, 5'd0, 5'd12, 16'h1234),   32'h14, 1'b1, 5'd12, 32'h1234_0000));
    vecs.push_back(mk(ei(6'h0F, 5'd0, 5'd13, 16'h1000),   32'h18, 1'b1, 5'd13, 32'h1000_0000));
    vecs.push_back(mk(ei(6'h2B, 5'd0, 5'd9, 16'd8),       32'h1C, 1'b0, 5'd0, 32'd0,
                      1'b1, 32'h0000_0008, 32'hFFFF_FFFF));
    vecs.push_back(mk(ei(6'h2B, 5'd13, 5'd9, 16'd16),     32'h20, 1'b0, 5'd0, 32'd0,
                      1'b1, 32'h1000_0010, 32'hFFFF_FFFF));
    vecs.push_back(mk(ei(6'h05, 5'd0, 5'd0, 16'd3),       32'h24, 1'b0, 5'd0, 32'd0));
    vecs.push_back(mk(ej(6'h02, 26'h8),                   32'h20, 1'b0, 5'd0, 32'd0));
    vecs.push_back(mk(ei(6'h04, 5'd0, 5'd0, 16'd3),       32'h30, 1'b0, 5'd0, 32'd0));
    vecs.push_back(mk(ei(6'h2B, 5'd0, 5'd8, 16'd16),      32'h34, 1'b0, 5'd0, 32'd0,
                      1'b1, 32'h0000_0010, 32'd5));
    vecs.push_back(mk(ei(6'h23, 5'd0, 5'd14, 16'd16),     32'h38, 1'b1, 5'd14, 32'd5));
    vecs.push_back(mk(ei(6'h0F, 5'd0, 5'd15, 16'hDEAD),   32'h3C, 1'b1, 5'd15, 32'hDEAD_0000));
    vecs.push_back(mk(ei(6'h0D, 5'd15, 5'd15, 16'hBEEF),  32'h40, 1'b1, 5'd15, 32'hDEAD_BEEF));
    vecs.push_back(mk(ej(6'h03, 26'h40),                  32'h100, 1'b1, 5'd31, 32'h44));
    vecs.push_back(mk(ei(6'h2B, 5'd13, 5'd15, 16'd8),     32'h104, 1'b0, 5'd0, 32'd0,
                      1'b1, 32'h1000_0008, 32'hDEAD_BEEF));
    vecs.push_back(mk(ei(6'h23, 5'd13, 5'd16, 16'd8),     32'h108, 1'b1, 5'd16, 32'hDEAD_BEEF));
    vecs.push_back(mk(er(5'd31, 5'd0, 5'd0, 5'd0, 6'h08), 32'h44, 1'b1, 5'd31, 32'h44));
    vecs.push_back(mk(ei(6'h08, 5'd0, 5'd0, 16'd7),       32'h48, 1'b1, 5'd0,  32'd0));
    vecs.push_back(mk(er(5'd0, 5'd8, 5'd17, 5'd0, 6'h21), 32'h4C, 1'b1, 5'd17, 32'd5));
    vecs.push_back(mk(er(5'd8, 5'd9, 5'd18, 5'd0, 6'h22), 32'h50, 1'b1, 5'd18, 32'd6));
    vecs.push_back(mk(er(5'd0, 5'd8, 5'd19, 5'd4, 6'h00), 32'h54, 1'b1, 5'd19, 32'h50));
    vecs.push_back(mk(er(5'd0, 5'd12, 5'd20, 5'd8, 6'h02), 32'h58, 1'b1, 5'd20, 32'h0012_3400));
    vecs.push_back(mk(er(5'd0, 5'd15, 5'd21, 5'd4, 6'h03), 32'h5C, 1'b1, 5'd21, 32'hFDEA_DBEE));
    vecs.push_back(mk(er(5'd0, 5'd8, 5'd22, 5'd0, 6'h27), 32'h60, 1'b1, 5'd22, 32'hFFFF_FFFA));
    vecs.push_back(mk(ei(6'h0E, 5'd8, 5'd23, 16'hFFFF),   32'h64, 1'b1, 5'd23, 32'h0000_FFFA));
    vecs.push_back(mk(ei(6'h0A, 5'd9, 5'd24, 16'd0),      32'h68, 1'b1, 5'd24, 32'd1));
    vecs.push_back(mk(ei(6'h0B, 5'd8, 5'd25, 16'hFFFF),   32'h6C, 1'b1, 5'd25, 32'd1));
    vecs.push_back(mk(er(5'd0, 5'd0, 5'd0, 5'd0, 6'h0C),  32'h70, 1'b1, 5'd8,  32'd5,
                      1'b0, 32'h0, 32'h0, 1'b1));
    vecs.push_back(mk(32'hFC08_0001,                      32'h74, 1'b1, 5'd8,  32'd5));
    vecs.push_back(mk(ei(6'h08, 5'd8, 5'd8, 16'd1),       32'h78, 1'b1, 5'd8,  32'd6));

    reset = 1'b0;
    instr = ei(6'h08, 5'd0, 5'd8, 16'd5);
    repeat (2) @(posedge clk);
    #1;
    check("reset_pc", pc, 32'h0);
    check("reset_sp", dut.u_datapath.regs[29], 32'h1000_0FFC);
    check("reset_r8", dut.u_datapath.regs[8], 32'h0);
    #1 reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    check("dmem_w2_kept", dut.dmem.Dmem[2], 32'hFFFF_FFFF);
    check("heap_w4_kept", dut.heap_ram.Dmem[4], 32'hFFFF_FFFF);
    check("dmem_w4", dut.dmem.Dmem[4], 32'd5);
    check("heap_w2", dut.heap_ram.Dmem[2], 32'hDEAD_BEEF);

    // Reset mid-instruction: a pending store must not commit and state clears at once.
    @(negedge clk);
    instr = ei(6'h2B, 5'd0, 5'd15, 16'd16);
    #2 reset = 1'b0;
    #1;
    check("midrst_pc", pc, 32'h0);
    check("midrst_r8", dut.u_datapath.regs[8], 32'h0);
    check("midrst_r15", dut.u_datapath.regs[15], 32'h0);
    check("midrst_sp", dut.u_datapath.regs[29], 32'h1000_0FFC);
    @(posedge clk);
    #1;
    check("midrst_pc_hold", pc, 32'h0);
    check("midrst_dmem_kept", dut.dmem.Dmem[4], 32'd5);
    check("midrst_heap_kept", dut.heap_ram.Dmem[2], 32'hDEAD_BEEF);
    #1 reset = 1'b1;
    apply(mk(ei(6'h08, 5'd0, 5'd8, 16'd5), 32'h04, 1'b1, 5'd8, 32'd5), 99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_sc_core.md
# mips_sc_core

Single-cycle MIPS32 subset processor core: control decoder, datapath (PC, register file, ALU), and a split data memory (low data RAM plus heap RAM at `HEAP_BASE`). Sits between the external instruction ROM (combinational fetch via `pc`/`instr`) and the simulation top level. One instruction completes per clock.

## Interface
- `HEAP_BASE`, 32'h1000_0000, first byte address routed to the heap RAM.
- `DMEM_WORDS`, 1024, depth of the data RAM in 32-bit words (power of two).
- `HEAP_WORDS`, 1024, depth of the heap RAM in words (power of two).
- `RESET_PC`, 32'h0000_0000, PC value after reset.
- `SP_INIT`, 32'h1000_0FFC, reset value of `$sp` (r29).
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `pc` out 32: current instruction byte address to the ROM.
- `instr` in 32: instruction word at `pc`, valid combinationally.
- `syscall` out 1: high while the current instruction is SYSCALL.
- `mem_addr` out 32, `mem_wdata` out 32, `mem_we` out 1: observation of the current store/load access.

## Operation
- Decode on `instr[31:26]` (op) and `instr[5:0]` (funct) into RegDst, RegWrite, ALUSrc, MemtoReg, MemWrite, Branch/PCSrc, Jump, JAL, JR, SysCall, 6-bit ALUControl.
- R-type: add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra (shamt), jr, syscall. I-type: addi, addiu, andi, ori, xori (zero-ext), slti, sltiu (sign-ext), lui, lw, sw, beq, bne. J-type: j, jal. Unknown opcodes/functs: no register or memory write, PC+4.
- No overflow traps; add/addi behave as addu/addiu. slt signed, sltu unsigned.
- Register file: 32x32, r0 reads 0 and ignores writes; two combinational reads, one write at clock edge. Destination rd (R), rt (I), r31 (JAL, data PC+4).
- Next PC: JR -> rs; Jump/JAL -> {PC+4[31:28], imm26, 2'b00}; taken branch (beq & Zero, bne & !Zero) -> PC+4 + (sext(imm16)<<2); else PC+4.
- Memory: effective address = rs + sext(imm16). Address >= `HEAP_BASE` selects heap RAM with offset addr-`HEAP_BASE`; else data RAM. Store enable gated to the selected RAM only; load data muxed from the selected RAM.
- Each RAM: word-indexed by offset[log2(words)+1:2]; byte offset bits ignored; upper bits wrap (modulo depth). Write synchronous, read combinational. Storage array named `Dmem` so benches preload via $readmemb through hierarchical path.
- SYSCALL: asserts `syscall`, otherwise a no-op (PC+4).

## Timing
- Reset (low): PC = `RESET_PC`, all registers 0 except r29 = `SP_INIT`; asserted mid-instruction, state clears immediately and no write commits. RAM contents not cleared by reset.
- After reset release, first edge executes instruction at `RESET_PC`.
- Every instruction: 1 cycle; register write, memory write, PC update at the same rising edge.
- lw immediately after sw to the same address returns the stored value (write at edge N, read combinational in cycle N+1).
- Instruction reading and writing the same register uses the old value (write occurs at cycle end).

## Structure
- Shared package: opcode/funct constants, ALUControl encodings, `HEAP_BASE` default.
- Sub-modules: `Controlunit` (pure combinational decoder), `Datapath` (PC, regfile, ALU, muxes), `ram` (instantiated twice as `dmem` and `heap_ram`). Top wires address split and read mux.

## Test plan
- Reset low then high with `instr`=addi r8,r0,5 -> `pc` 0 then 4; r8 = 5; r29 = 0x1000_0FFC.
- addi r9,r0,-1; sltu r10,r0,r9; slt r11,r0,r9 -> r10 = 1, r11 = 0; lui r12,0x1234 -> r12 = 0x1234_0000.
- sw r8 to 0x0000_0010 then lw -> data RAM word 4 = 5, heap unchanged, load returns 5.
- sw to 0x1000_0008 (value 0xDEAD_BEEF) -> heap word 2 written, data RAM word 2 unchanged; lw returns 0xDEAD_BEEF.
- beq r0,r0,+3 at pc 0x20 -> next pc 0x30; bne r0,r0 -> pc 0x24; jal 0x100 at 0x40 -> pc 0x100, r31 = 0x44; jr r31 -> pc 0x44.
- Write to r0 then read -> 0; reset asserted mid-run -> pc 0 asynchronously, memories retain data.
